// File: rtl/vae_pkg.sv
// Shared defaults, FSM state type and hard-sigmoid constants for the VAE activation datapath.
package vae_pkg;

    localparam int VAE_INPUT_NUMBER = 100;
    localparam int VAE_WIDTH        = 10;
    localparam int VAE_FRAC_BITS    = 6;

    // Hard sigmoid: clamp((x >>> HSIG_SHIFT) + 0.5, 0, 1.0) in the element's fixed-point format.
    localparam int HSIG_SHIFT = 2;

    function automatic int hsig_offset(input int frac_bits);
        return 1 << (frac_bits - 1);
    endfunction

    function automatic int hsig_upper(input int frac_bits);
        return 1 << frac_bits;
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

endpackage

// File: rtl/vec_serializer_if.sv
// Handshake bundle for vec_serializer: parallel vector in, indexed element stream out.
interface vec_serializer_if
    import vae_pkg::*;
#(
    parameter int N = VAE_INPUT_NUMBER,
    parameter int W = VAE_WIDTH
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic                 in_valid;
    logic                 in_ready;
    logic signed [W-1:0]  in_vec [0:N-1];
    logic                 out_valid;
    logic                 out_ready;
    logic signed [W-1:0]  out_data;
    logic        [IW-1:0] out_index;
    logic                 out_last;

    modport master (
        output in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_data, out_index, out_last
    );

    modport slave (
        input  in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_data, out_index, out_last
    );

endinterface

// File: rtl/hard_sigmoid.sv
// Element activation f(): hard sigmoid when VEC_SERIALIZER_HSIGMOID_EN is defined, else bit-exact passthrough.
module hard_sigmoid
    import vae_pkg::*;
#(
    parameter int width     = VAE_WIDTH,
    parameter int frac_bits = VAE_FRAC_BITS
) (
    input  logic signed [width-1:0] x,
    output logic signed [width-1:0] y
);

    if (frac_bits < 1 || frac_bits > width - 2) begin : g_bad_cfg
        $error("hard_sigmoid: frac_bits must be in 1..width-2");
    end

`ifdef VEC_SERIALIZER_HSIGMOID_EN
    localparam logic signed [width:0] OFFSET = (width+1)'(hsig_offset(frac_bits));
    localparam logic signed [width:0] UPPER  = (width+1)'(hsig_upper(frac_bits));

    logic signed [width:0] x_ext;
    logic signed [width:0] shifted;
    logic signed [width:0] sum;

    // One extra bit keeps the offset add from overflowing before the clamp.
    always_comb begin
        x_ext   = {x[width-1], x};
        shifted = x_ext >>> HSIG_SHIFT;
        sum     = shifted + OFFSET;
        if (sum < 0) begin
            y = '0;
        end else if (sum > UPPER) begin
            y = UPPER[width-1:0];
        end else begin
            y = sum[width-1:0];
        end
    end
`else
    assign y = x;
`endif

endmodule

// File: rtl/vec_serializer.sv
// Captures a parallel activation vector and streams it element by element with valid/ready.
// Optional hard-sigmoid on each element: define VEC_SERIALIZER_HSIGMOID_EN.
module vec_serializer
    import vae_pkg::*;
#(
    parameter int input_number = VAE_INPUT_NUMBER,
    parameter int width        = VAE_WIDTH,
    parameter int frac_bits    = VAE_FRAC_BITS
) (
    input  logic clk,
    input  logic rst_n,
    vec_serializer_if.slave bus
);

    localparam int IW = (input_number > 1) ? $clog2(input_number) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(input_number - 1);

    if (input_number < 2) begin : g_bad_n
        $error("vec_serializer: input_number must be at least 2");
    end

    ser_state_e              state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic signed [width-1:0] buf_q [0:input_number-1];
    logic signed [width-1:0] buf_d [0:input_number-1];

    logic                    out_valid_q, out_valid_d;
    logic signed [width-1:0] out_data_q, out_data_d;
    logic [IW-1:0]           out_index_q, out_index_d;
    logic                    out_last_q, out_last_d;
    logic                    in_ready_q, in_ready_d;

    logic signed [width-1:0] rd_elem;
    logic signed [width-1:0] f_elem;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    buf_d   = bus.in_vec;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered, so the read mux looks at next-cycle buffer/index;
    // on capture that is the incoming vector itself.
    always_comb begin
        rd_elem = buf_d[idx_d];
    end

    hard_sigmoid #(
        .width     (width),
        .frac_bits (frac_bits)
    ) u_hard_sigmoid (
        .x (rd_elem),
        .y (f_elem)
    );

    always_comb begin
        out_valid_d = (state_d == SEND);
        in_ready_d  = (state_d == IDLE);
        out_data_d  = out_valid_d ? f_elem : '0;
        out_index_d = out_valid_d ? idx_d : '0;
        out_last_d  = out_valid_d && (idx_d == LAST_IDX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            buf_q       <= '{default: '0};
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            buf_q       <= buf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_index = out_index_q;
    assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_vec_serializer.sv
// Self-checking bench for vec_serializer (N=4, width=10, frac_bits=6), directed plus randomized traffic.
module tb_vec_serializer;
    import vae_pkg::*;

    localparam int N  = 4;
    localparam int W  = 10;
    localparam int FB = 6;

    typedef struct {
        int data;
        int idx;
        int last;
    } ent_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    vec_serializer_if #(.N(N), .W(W)) bus ();

    vec_serializer #(
        .input_number (N),
        .width        (W),
        .frac_bits    (FB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    ent_t exp_q[$];
    ent_t log_q[$];
    int   acc_cyc[$];
    bit   rnd_done;

    // Reference f(): floor-divide by 4, add one half, clamp to [0, 1.0].
    function automatic int model_f(input int v);
`ifdef VEC_SERIALIZER_HSIGMOID_EN
        int r;
        int q;
        r = ((v % 4) + 4) % 4;
        q = (v - r) / 4 + (2 ** (FB - 1));
        if (q < 0) return 0;
        if (q > 2 ** FB) return 2 ** FB;
        return q;
`else
        return v;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Model: a vector accepted while idle becomes N queued elements; each ready cycle retires one.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            check("rst_out_valid", int'(bus.out_valid), 0);
            check("rst_in_ready", int'(bus.in_ready), 1);
        end else if (exp_q.size() != 0) begin
            check("out_valid", int'(bus.out_valid), 1);
            check("in_ready_busy", int'(bus.in_ready), 0);
            check("out_data", int'(bus.out_data), exp_q[0].data);
            check("out_index", int'(bus.out_index), exp_q[0].idx);
            check("out_last", int'(bus.out_last), exp_q[0].last);
            if (bus.out_ready) begin
                log_q.push_back('{int'(bus.out_data), int'(bus.out_index), int'(bus.out_last)});
                void'(exp_q.pop_front());
            end
        end else begin
            check("idle_out_valid", int'(bus.out_valid), 0);
            check("idle_in_ready", int'(bus.in_ready), 1);
            check("idle_out_data", int'(bus.out_data), 0);
            check("idle_out_index", int'(bus.out_index), 0);
            check("idle_out_last", int'(bus.out_last), 0);
            if (bus.in_valid) begin
                acc_cyc.push_back(cyc);
                for (int i = 0; i < N; i++)
                    exp_q.push_back('{model_f(int'(bus.in_vec[i])), i, (i == N - 1) ? 1 : 0});
            end
        end
    end

    task automatic send_vec(input int a [0:N-1]);
        int k;
        bit ok;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) bus.in_vec[i] = W'(a[i]);
        bus.in_valid = 1'b1;
        ok = 1'b0;
        k  = 0;
        while (!ok && k < 300) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            k++;
        end
        #1;
        bus.in_valid = 1'b0;
        check("vector_accepted", int'(ok), 1);
    endtask

    task automatic wait_log(input int n);
        int k;
        k = 0;
        while (log_q.size() < n && k < 300) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("log_count_reached", int'(log_q.size() >= n), 1);
    endtask

    task automatic check_log(input string tag, input int base, input int e [0:N-1]);
        for (int i = 0; i < N; i++) begin
            if (base + i < log_q.size()) begin
                check({tag, "_data"}, log_q[base+i].data, e[i]);
                check({tag, "_index"}, log_q[base+i].idx, i);
                check({tag, "_last"}, log_q[base+i].last, (i == N - 1) ? 1 : 0);
            end else begin
                check({tag, "_missing"}, log_q.size(), base + N);
            end
        end
    endtask

    int a_in  [0:N-1] = '{5, -3, 0, 511};
    int b_in  [0:N-1] = '{0, 64, 256, -256};
    int c_in  [0:N-1] = '{-1, 100, -100, 7};
`ifdef VEC_SERIALIZER_HSIGMOID_EN
    int a_exp [0:N-1] = '{33, 31, 32, 64};
    int b_exp [0:N-1] = '{32, 48, 64, 0};
    int c_exp [0:N-1] = '{31, 57, 7, 33};
`else
    int a_exp [0:N-1] = '{5, -3, 0, 511};
    int b_exp [0:N-1] = '{0, 64, 256, -256};
    int c_exp [0:N-1] = '{-1, 100, -100, 7};
`endif

    initial begin
        int base;
        int ab;
        int k;
        int r_in [0:N-1];

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < N; i++) bus.in_vec[i] = '0;

        #2 rst_n = 1'b0;
        #1;
        check("reset_out_valid", int'(bus.out_valid), 0);
        check("reset_in_ready", int'(bus.in_ready), 1);
        check("reset_out_data", int'(bus.out_data), 0);
        check("reset_out_index", int'(bus.out_index), 0);
        check("reset_out_last", int'(bus.out_last), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Pin the reference f() against hand-computed values.
        for (int i = 0; i < N; i++) begin
            check("model_pin_b", model_f(b_in[i]), b_exp[i]);
            check("model_pin_c", model_f(c_in[i]), c_exp[i]);
        end

        // Single vectors, full-rate drain; idle again right after the last element.
        base = log_q.size();
        send_vec(a_in);
        wait_log(base + N);
        check_log("vec_a", base, a_exp);
        check("ready_after_last", int'(bus.in_ready), 1);
        check("gap_out_valid", int'(bus.out_valid), 0);

        base = log_q.size();
        send_vec(b_in);
        wait_log(base + N);
        check_log("vec_b", base, b_exp);

        base = log_q.size();
        send_vec(c_in);
        wait_log(base + N);
        check_log("vec_c", base, c_exp);

        // Backpressure: three stalled cycles on index 1.
        base = log_q.size();
        send_vec(a_in);
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bp_valid", int'(bus.out_valid), 1);
            check("bp_index", int'(bus.out_index), 1);
            check("bp_data", int'(bus.out_data), a_exp[1]);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        wait_log(base + N);
        check_log("bp", base, a_exp);
        check("bp_count", log_q.size() - base, N);

        // Input hold-off: in_valid stays high with changing data during SEND.
        base = log_q.size();
        ab   = acc_cyc.size();
        send_vec(b_in);
        bus.in_valid = 1'b1;
        for (int i = 0; i < N; i++) bus.in_vec[i] = W'($urandom_range(0, 1023));
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) bus.in_vec[i] = W'($urandom_range(0, 1023));
        send_vec(c_in);
        wait_log(base + 2 * N);
        check_log("hold_first", base, b_exp);
        check_log("hold_second", base + N, c_exp);
        if (acc_cyc.size() >= ab + 2)
            check("hold_accept_spacing", acc_cyc[ab+1] - acc_cyc[ab], N + 1);
        else
            check("hold_accept_count", acc_cyc.size() - ab, 2);

        // Reset while index 2 is on the output.
        base = log_q.size();
        send_vec(c_in);
        k = 0;
        while (k < 20) begin
            @(posedge clk);
            #1;
            if (bus.out_valid && bus.out_index == 2) break;
            k++;
        end
        check("reached_idx2", int'(bus.out_index), 2);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", int'(bus.out_valid), 0);
        check("midrst_in_ready", int'(bus.in_ready), 1);
        check("midrst_out_index", int'(bus.out_index), 0);
        check("midrst_out_data", int'(bus.out_data), 0);
        check("midrst_out_last", int'(bus.out_last), 0);
        check("midrst_emitted", log_q.size() - base, 2);
        for (int i = base; i < log_q.size(); i++)
            check("midrst_no_last", log_q[i].last, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        base = log_q.size();
        send_vec(a_in);
        wait_log(base + N);
        check_log("after_rst", base, a_exp);

        // Randomized vectors with random downstream readiness.
        rnd_done = 1'b0;
        fork
            begin
                for (int t = 0; t < 25; t++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    for (int i = 0; i < N; i++) r_in[i] = int'($urandom_range(0, 1023)) - 512;
                    send_vec(r_in);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.out_ready = 1'b1;
        k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            @(posedge clk);
            k++;
        end
        @(negedge clk);
        #1;
        check("random_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vec_serializer.md
VEC_SERIALIZER -- requirements
Module: vec_serializer

Interface
REQ-001 SHALL have parameter input_number, default 100: elements per vector (N), at least 2.
REQ-002 SHALL have parameter width, default 10: signed element width.
REQ-003 SHALL have parameter frac_bits, default 6: fractional bits of the fixed-point element; at most width-2.
REQ-004 SHALL have port clk  input  1  single clock, rising edge; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port in_valid  input  1  parallel vector present.
REQ-007 SHALL have port in_ready  output  1  block accepts a vector.
REQ-008 SHALL have port in_vec  input  signed width x [0:N-1]  parallel activation vector, as produced by the layer activation stage.
REQ-009 SHALL have port out_valid  output  1  stream element valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the element.
REQ-011 SHALL have port out_data  output  signed width  stream element.
REQ-012 SHALL have port out_index  output  clog2(N)  element index of out_data.
REQ-013 SHALL have port out_last  output  1  marks element N-1.

Function
REQ-014 SHALL implement an FSM with states IDLE and SEND.
REQ-015 SHALL drive in_ready=1 only in IDLE.
REQ-016 SHALL, on in_valid&&in_ready, capture all N elements into an internal buffer, clear idx to 0 and enter SEND.
REQ-017 SHALL drive out_valid=1 in SEND; first element valid in the cycle after capture (latency 1).
REQ-018 SHALL present out_data=f(buf[idx]), out_index=idx, out_last=(idx==N-1) while in SEND.
REQ-019 SHALL hold out_data, out_index and out_last stable while out_valid&&!out_ready.
REQ-020 SHALL, on out_valid&&out_ready with idx<N-1, increment idx.
REQ-021 SHALL, on out_valid&&out_ready with idx==N-1, return to IDLE; throughput is N+1 cycles per vector.
REQ-022 SHALL ignore in_valid and in_vec changes during SEND; the buffer is immune to them.
REQ-023 SHALL force out_data, out_index and out_last to 0 whenever out_valid=0.
REQ-024 SHALL never wrap idx past N-1.

Reset
REQ-025 SHALL, on rst_n low, immediately set state=IDLE, idx=0, out_valid=0, out_data=0, out_index=0, out_last=0, in_ready=1, buffer cleared.
REQ-026 SHALL, on reset mid-SEND, discard the vector without emitting out_last; the first vector after reset starts at index 0.

Configuration
REQ-027 SHALL, with macro VEC_SERIALIZER_HSIGMOID_EN defined, compute f(x)=clamp((x>>>2)+2^(frac_bits-1), 0, 2^frac_bits), using arithmetic shift and an intermediate width+1 bits wide.
REQ-028 SHALL, without VEC_SERIALIZER_HSIGMOID_EN, compute f(x)=x as a bit-exact passthrough.

Structure
REQ-029 SHALL place the default width and frac_bits, the FSM state typedef (IDLE, SEND) and the hard-sigmoid constants in the shared package vae_pkg.
REQ-030 SHALL implement f() in one combinational sub-module, hard_sigmoid, instantiated once on the buffer read mux output.

Verification (N=4, width=10, frac_bits=6)
REQ-031 SHALL cover passthrough: in_vec={5,-3,0,511}, out_ready=1 -> out_data 5,-3,0,511 on consecutive cycles, idx 0..3, out_last only with 511, in_ready=1 on the following cycle.
REQ-032 SHALL cover HSIGMOID_EN: in_vec={0,64,256,-256} -> out_data 32,48,64,0; in_vec={-1,...} -> first element 31.
REQ-033 SHALL cover backpressure: out_ready=0 for 3 cycles at idx 1 -> out_data, out_index and out_valid held for 3 cycles, no element lost or duplicated.
REQ-034 SHALL cover input hold-off: in_valid held high with a new vector during SEND -> ignored; accepted only in the IDLE cycle after out_last; the two vectors are output in order.
REQ-035 SHALL cover reset mid-operation: rst_n low at idx 2 -> out_valid=0 and in_ready=1 immediately; the next vector streams from index 0.
